// File: rtl/tmds_encoder_multi.sv
// NUM_CH-lane TMDS encoder (video 8b/10b, control, TERC4, guard band), each lane with its own disparity.
// Two-register pipeline, fixed 2 PIXCLK latency, one symbol per lane per cycle, never stalls.
module tmds_encoder_multi #(
  parameter int NUM_CH = 3
) (
  input  logic                 PIXCLK,
  input  logic                 RST,
  input  logic [1:0]           MODE,
  input  logic [8*NUM_CH-1:0]  DATA,
  input  logic [2*NUM_CH-1:0]  CTRL,
  input  logic [4*NUM_CH-1:0]  AUX,
  output logic [10*NUM_CH-1:0] TMDSencDATA,
  output logic                 VALID
);

  localparam logic [1:0] MODE_CTRL  = 2'b00;
  localparam logic [1:0] MODE_VIDEO = 2'b01;
  localparam logic [1:0] MODE_TERC4 = 2'b10;
  localparam logic [1:0] MODE_GUARD = 2'b11;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] s;
    s = '0;
    for (int i = 0; i < 8; i++) s = s + {3'b000, v[i]};
    return s;
  endfunction

  function automatic logic [9:0] ctrl_sym(input logic [1:0] c);
    case (c)
      2'b00: return 10'b1101010100;
      2'b01: return 10'b0010101011;
      2'b10: return 10'b0101010100;
      2'b11: return 10'b1010101011;
    endcase
  endfunction

  function automatic logic [9:0] terc4_sym(input logic [3:0] a);
    case (a)
      4'h0: return 10'b1010011100;
      4'h1: return 10'b1001100011;
      4'h2: return 10'b1011100100;
      4'h3: return 10'b1011100010;
      4'h4: return 10'b0101110001;
      4'h5: return 10'b0100011110;
      4'h6: return 10'b0110001110;
      4'h7: return 10'b0100111100;
      4'h8: return 10'b1011001100;
      4'h9: return 10'b0100111001;
      4'hA: return 10'b0110011100;
      4'hB: return 10'b1011000110;
      4'hC: return 10'b1010001110;
      4'hD: return 10'b1001110001;
      4'hE: return 10'b0101100011;
      4'hF: return 10'b1011000011;
    endcase
  endfunction

  logic [1:0] mode_s1;
  logic       valid_s1;

  // After reset stage 1 holds MODE_CTRL/CTRL=00, so stage 2 keeps emitting control code 00.
  always_ff @(posedge PIXCLK) begin
    if (RST) begin
      mode_s1  <= MODE_CTRL;
      valid_s1 <= 1'b0;
      VALID    <= 1'b0;
    end else begin
      mode_s1  <= MODE;
      valid_s1 <= 1'b1;
      VALID    <= valid_s1;
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
    localparam logic [9:0] GUARD = (k % 3 == 1) ? 10'b0100110011 : 10'b1011001100;

    logic [7:0]        d;
    logic [3:0]        n1d;
    logic              flip;
    logic [8:0]        qm_c;
    logic [8:0]        qm;
    logic [3:0]        n1q;
    logic [1:0]        ctrl_s1;
    logic [3:0]        aux_s1;
    logic signed [4:0] cnt;
    logic signed [4:0] cnt_nxt;
    logic signed [4:0] diff;
    logic [9:0]        sym;
    logic [9:0]        sym_q;

    assign d = DATA[8*k +: 8];

    always_comb begin
      n1d     = popcount8(d);
      flip    = (n1d > 4'd4) || (n1d == 4'd4 && !d[0]);
      qm_c    = '0;
      qm_c[0] = d[0];
      for (int i = 1; i < 8; i++) qm_c[i] = flip ? ~(qm_c[i-1] ^ d[i]) : (qm_c[i-1] ^ d[i]);
      qm_c[8] = ~flip;
    end

    always_ff @(posedge PIXCLK) begin
      if (RST) begin
        qm      <= '0;
        n1q     <= '0;
        ctrl_s1 <= '0;
        aux_s1  <= '0;
      end else begin
        qm      <= qm_c;
        n1q     <= popcount8(qm_c[7:0]);
        ctrl_s1 <= CTRL[2*k +: 2];
        aux_s1  <= AUX[4*k +: 4];
      end
    end

    // diff = n1q - n0q; every non-video symbol restarts the running disparity at zero.
    always_comb begin
      diff    = signed'({n1q, 1'b0} - 5'd8);
      cnt_nxt = '0;
      sym     = ctrl_sym(ctrl_s1);
      case (mode_s1)
        MODE_VIDEO: begin
          if (cnt == 5'sd0 || n1q == 4'd4) begin
            sym     = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
            cnt_nxt = qm[8] ? cnt + diff : cnt - diff;
          end else if ((!cnt[4] && n1q > 4'd4) || (cnt[4] && n1q < 4'd4)) begin
            sym     = {1'b1, qm[8], ~qm[7:0]};
            cnt_nxt = cnt + (qm[8] ? 5'sd2 : 5'sd0) - diff;
          end else begin
            sym     = {1'b0, qm[8], qm[7:0]};
            cnt_nxt = cnt - (qm[8] ? 5'sd0 : 5'sd2) + diff;
          end
        end
        MODE_CTRL:  sym = ctrl_sym(ctrl_s1);
        MODE_TERC4: sym = terc4_sym(aux_s1);
        MODE_GUARD: sym = GUARD;
      endcase
    end

    always_ff @(posedge PIXCLK) begin
      if (RST) begin
        cnt   <= '0;
        sym_q <= 10'b1101010100;
      end else begin
        cnt   <= cnt_nxt;
        sym_q <= sym;
      end
    end

    assign TMDSencDATA[10*k +: 10] = sym_q;
  end

endmodule

// File: tb/tb_tmds_encoder_multi.sv
// Bench for tmds_encoder_multi with NUM_CH=4: reset sequence, a hand-computed vector table,
// then a random stream with reset pulses checked against a behavioural reference.
module tb_tmds_encoder_multi;
  localparam int NC = 4;
  localparam logic [9:0] C0  = 10'b1101010100;
  localparam logic [9:0] GB0 = 10'b1011001100;
  localparam logic [9:0] GB1 = 10'b0100110011;

  logic              PIXCLK = 1'b0;
  logic              RST;
  logic [1:0]        MODE;
  logic [8*NC-1:0]   DATA;
  logic [2*NC-1:0]   CTRL;
  logic [4*NC-1:0]   AUX;
  logic [10*NC-1:0]  TMDSencDATA;
  logic              VALID;

  int checks = 0;
  int failures = 0;

  tmds_encoder_multi #(.NUM_CH(NC)) dut (
    .PIXCLK(PIXCLK), .RST(RST), .MODE(MODE), .DATA(DATA), .CTRL(CTRL), .AUX(AUX),
    .TMDSencDATA(TMDSencDATA), .VALID(VALID)
  );

  always #5 PIXCLK = ~PIXCLK;

  typedef struct packed {
    logic [1:0]       mode;
    logic [7:0]       d0;
    logic [7:0]       d1;
    logic [1:0]       ctl;
    logic [3:0]       aux;
    logic [3:0][9:0]  e;
  } vec_t;

  vec_t       tab[$];
  logic [9:0] ctrl_tab [4];
  logic [9:0] terc_tab [16];

  task automatic step();
    @(posedge PIXCLK);
    #1;
  endtask

  task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  function automatic logic [9:0] lane(input int k);
    return TMDSencDATA[10*k +: 10];
  endfunction

  task automatic drive(input logic [1:0] m, input logic [7:0] d0, input logic [7:0] d1,
                       input logic [1:0] c, input logic [3:0] a);
    MODE = m;
    DATA = {d1, d0, d1, d0};
    CTRL = {NC{c}};
    AUX  = {NC{a}};
  endtask

  task automatic add(input logic [1:0] m, input logic [7:0] d0, input logic [7:0] d1,
                     input logic [1:0] c, input logic [3:0] a,
                     input logic [9:0] e0, input logic [9:0] e1,
                     input logic [9:0] e2, input logic [9:0] e3);
    vec_t v;
    v.mode = m; v.d0 = d0; v.d1 = d1; v.ctl = c; v.aux = a;
    v.e[0] = e0; v.e[1] = e1; v.e[2] = e2; v.e[3] = e3;
    tab.push_back(v);
  endtask

  // Reference video coder: q_m built as prefix parity, odd bits inverted when the XNOR path is taken.
  function automatic logic [9:0] ref_video(input logic [7:0] d, input int cin, output int cout);
    int n1, n1q, n0q, b8;
    logic [7:0] q;
    logic f, p;
    n1 = $countones(d);
    f  = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
    p  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      p    = p ^ d[i];
      q[i] = p ^ (f & i[0]);
    end
    b8  = f ? 0 : 1;
    n1q = $countones(q);
    n0q = 8 - n1q;
    if (cin == 0 || n1q == n0q) begin
      cout = cin + ((b8 == 1) ? (n1q - n0q) : (n0q - n1q));
      return (b8 == 1) ? {2'b01, q} : {2'b10, ~q};
    end
    if ((cin > 0 && n1q > n0q) || (cin < 0 && n0q > n1q)) begin
      cout = cin + 2 * b8 + n0q - n1q;
      return {1'b1, b8[0], ~q};
    end
    cout = cin - 2 * (1 - b8) + n1q - n0q;
    return {1'b0, b8[0], q};
  endfunction

  function automatic logic [9:0] ref_sym(input int k, input logic [1:0] m, input logic [7:0] d,
                                         input logic [1:0] c, input logic [3:0] a,
                                         input int cin, output int cout);
    cout = 0;
    case (m)
      2'b00:   return ctrl_tab[c];
      2'b10:   return terc_tab[a];
      2'b11:   return (k % 3 == 1) ? GB1 : GB0;
      default: return ref_video(d, cin, cout);
    endcase
  endfunction

  initial begin
    int mcnt [NC];
    int ds [NC];
    logic [9:0] pend [NC];
    logic [9:0] nxt [NC];
    logic [9:0] expv;
    logic pend_vid, rst_b, ds_ok;
    logic [1:0] md;
    int vcnt, cout;

    ctrl_tab[0] = 10'b1101010100; ctrl_tab[1] = 10'b0010101011;
    ctrl_tab[2] = 10'b0101010100; ctrl_tab[3] = 10'b1010101011;
    terc_tab[0]  = 10'b1010011100; terc_tab[1]  = 10'b1001100011;
    terc_tab[2]  = 10'b1011100100; terc_tab[3]  = 10'b1011100010;
    terc_tab[4]  = 10'b0101110001; terc_tab[5]  = 10'b0100011110;
    terc_tab[6]  = 10'b0110001110; terc_tab[7]  = 10'b0100111100;
    terc_tab[8]  = 10'b1011001100; terc_tab[9]  = 10'b0100111001;
    terc_tab[10] = 10'b0110011100; terc_tab[11] = 10'b1011000110;
    terc_tab[12] = 10'b1010001110; terc_tab[13] = 10'b1001110001;
    terc_tab[14] = 10'b0101100011; terc_tab[15] = 10'b1011000011;

    // Lanes 0/2 carry d0, lanes 1/3 carry d1; rows run back-to-back so disparity carries over.
    add(2'b01, 8'h00, 8'hFF, 2'b00, 4'h0, 10'b0100000000, 10'b1000000000, 10'b0100000000, 10'b1000000000);
    add(2'b01, 8'h00, 8'hFF, 2'b00, 4'h0, 10'b1111111111, 10'b0011111111, 10'b1111111111, 10'b0011111111);
    add(2'b01, 8'h00, 8'hFF, 2'b00, 4'h0, 10'b0100000000, 10'b0011111111, 10'b0100000000, 10'b0011111111);
    add(2'b00, 8'h00, 8'hFF, 2'b01, 4'h0, 10'b0010101011, 10'b0010101011, 10'b0010101011, 10'b0010101011);
    add(2'b01, 8'h00, 8'hFF, 2'b00, 4'h0, 10'b0100000000, 10'b1000000000, 10'b0100000000, 10'b1000000000);
    for (int i = 0; i < 16; i++)
      add(2'b10, 8'h00, 8'hFF, 2'b00, 4'(i), terc_tab[i], terc_tab[i], terc_tab[i], terc_tab[i]);
    add(2'b11, 8'h00, 8'hFF, 2'b00, 4'h0, GB0, GB1, GB0, GB0);
    add(2'b00, 8'h00, 8'hFF, 2'b00, 4'h0, C0, C0, C0, C0);
    add(2'b00, 8'h00, 8'hFF, 2'b10, 4'h0, 10'b0101010100, 10'b0101010100, 10'b0101010100, 10'b0101010100);
    add(2'b00, 8'h00, 8'hFF, 2'b11, 4'h0, 10'b1010101011, 10'b1010101011, 10'b1010101011, 10'b1010101011);
    add(2'b01, 8'h00, 8'hFF, 2'b00, 4'h0, 10'b0100000000, 10'b1000000000, 10'b0100000000, 10'b1000000000);
    add(2'b01, 8'h55, 8'h0F, 2'b00, 4'h0, 10'b0100110011, 10'b1111111010, 10'b0100110011, 10'b1111111010);
    add(2'b01, 8'h80, 8'h0F, 2'b00, 4'h0, 10'b1101111111, 10'b1111111010, 10'b1101111111, 10'b1111111010);
    add(2'b01, 8'hFE, 8'h0F, 2'b00, 4'h0, 10'b1011111111, 10'b0100000101, 10'b1011111111, 10'b0100000101);
    add(2'b01, 8'hFE, 8'h0F, 2'b00, 4'h0, 10'b0000000000, 10'b0100000101, 10'b0000000000, 10'b0100000101);

    // Reset held with live video on the inputs.
    RST = 1'b1;
    drive(2'b01, 8'hFF, 8'hFF, 2'b00, 4'h0);
    for (int r = 0; r < 3; r++) begin
      step();
      for (int k = 0; k < NC; k++) check($sformatf("reset%0d_lane%0d", r, k), lane(k), C0);
      check($sformatf("reset%0d_valid", r), {9'd0, VALID}, 10'd0);
    end
    RST = 1'b0;
    drive(2'b00, 8'h00, 8'h00, 2'b00, 4'h0);
    step();
    check("valid_release_1", {9'd0, VALID}, 10'd0);
    step();
    check("valid_release_2", {9'd0, VALID}, 10'd1);

    for (int i = 0; i <= tab.size(); i++) begin
      if (i < tab.size()) drive(tab[i].mode, tab[i].d0, tab[i].d1, tab[i].ctl, tab[i].aux);
      else drive(2'b00, 8'h00, 8'h00, 2'b00, 4'h0);
      step();
      if (i >= 1)
        for (int k = 0; k < NC; k++)
          check($sformatf("vec%0d_lane%0d", i - 1, k), lane(k), tab[i-1].e[k]);
    end

    // Random stream; the idle control symbol driven last is still in flight.
    for (int k = 0; k < NC; k++) begin
      mcnt[k] = 0; ds[k] = 0; pend[k] = C0;
    end
    pend_vid = 1'b0;
    vcnt = 10;
    for (int c = 0; c < 3000; c++) begin
      rst_b = (c == 40) || ($urandom_range(0, 299) == 0);
      md    = ($urandom_range(0, 15) < 13) ? 2'b01 : 2'($urandom_range(0, 3));
      RST   = rst_b;
      MODE  = md;
      DATA  = $urandom();
      CTRL  = 8'($urandom());
      AUX   = 16'($urandom());
      for (int k = 0; k < NC; k++) begin
        if (rst_b) begin
          nxt[k] = C0;
          mcnt[k] = 0;
        end else begin
          nxt[k] = ref_sym(k, md, DATA[8*k +: 8], CTRL[2*k +: 2], AUX[4*k +: 4], mcnt[k], cout);
          mcnt[k] = cout;
        end
      end
      step();
      ds_ok = 1'b1;
      for (int k = 0; k < NC; k++) begin
        expv = rst_b ? C0 : pend[k];
        check($sformatf("stream%0d_lane%0d", c, k), lane(k), expv);
        if (!rst_b && pend_vid) ds[k] = ds[k] + 2 * $countones(lane(k)) - 10;
        else ds[k] = 0;
        if (ds[k] > 10 || ds[k] < -10) ds_ok = 1'b0;
        pend[k] = nxt[k];
      end
      check($sformatf("stream%0d_disparity_bound", c), {9'd0, ds_ok}, 10'd1);
      vcnt = rst_b ? 0 : vcnt + 1;
      check($sformatf("stream%0d_valid", c), {9'd0, VALID}, {9'd0, vcnt >= 2});
      pend_vid = !rst_b && (md == 2'b01);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tmds_encoder_multi.md
# tmds_encoder_multi

Parametrised multi-channel TMDS encoder for the HDMI 1.4a transmit path. Sits between the pixel/packet formatter and the 10:1 serialisers. Encodes NUM_CH lanes in parallel, each with its own running-disparity counter, and supports four period types: control, video data, TERC4 data island, and video guard band. Both the control symbols and the 8b/10b video coding are produced on the pixel clock.

## Interface
- NUM_CH, 3: number of TMDS lanes; range 1..8.
- PIXCLK  in  1  pixel clock; all logic is on the rising edge.
- RST  in  1  reset; synchronous, active-high.
- MODE  in  2  period type shared by all lanes: 00 control, 01 video, 10 data island (TERC4), 11 video guard band.
- DATA  in  8*NUM_CH  video bytes; lane k is DATA[8k+7:8k].
- CTRL  in  2*NUM_CH  control pairs; lane k is CTRL[2k+1:2k].
- AUX  in  4*NUM_CH  TERC4 nibbles; lane k is AUX[4k+3:4k].
- TMDSencDATA  out  10*NUM_CH  encoded symbols; lane k is bits [10k+9:10k], bit 0 is transmitted first.
- VALID  out  1  high once the pipeline holds post-reset data.

## Operation
- **Stage 1 (registered), per lane:**
  - N1 = popcount(DATA).
  - Flag f = (N1>4) || (N1==4 && DATA[0]==0).
  - q_m[0] = D[0].
  - q_m[i] = q_m[i-1] XOR D[i] when f==0, or XNOR when f==1, for i=1..7.
  - q_m[8] = ~f.
  - Register q_m[8:0], n1q = popcount(q_m[7:0]), MODE, CTRL and AUX.
- **Stage 2 (registered), per lane:** uses the signed 5-bit disparity cnt and n0q = 8-n1q.
  - **Case A (cnt==0 or n1q==n0q):**
    - out = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]}.
    - cnt += q_m[8] ? (n1q-n0q) : (n0q-n1q).
  - **Case B ((cnt>0 && n1q>n0q) or (cnt<0 && n0q>n1q)):**
    - out = {1, q_m[8], ~q_m[7:0]}.
    - cnt += 2*q_m[8] + n0q - n1q.
  - **Case C (otherwise):**
    - out = {0, q_m[8], q_m[7:0]}.
    - cnt += -2*~q_m[8] + n1q - n0q.
- **Disparity range:** all disparity arithmetic is 5-bit two's complement. Legal cnt stays within -10..+10; no saturation logic.
- **Non-video periods:** cnt is cleared to 0 on every stage-2 cycle whose registered MODE is not 01.
- **Control codes (MODE 00):**
  - 00 → 1101010100
  - 01 → 0010101011
  - 10 → 0101010100
  - 11 → 1010101011
- **TERC4 (MODE 10), AUX nibble 0..F in order:**
  - 0–3: 1010011100, 1001100011, 1011100100, 1011100010
  - 4–7: 0101110001, 0100011110, 0110001110, 0100111100
  - 8–B: 1011001100, 0100111001, 0110011100, 1011000110
  - C–F: 1010001110, 1001110001, 0101100011, 1011000011
- **Guard band (MODE 11):**
  - Lanes with k mod 3 == 1 output 0100110011.
  - All other lanes output 1011001100.
- **Lane independence:** lanes share only PIXCLK, RST and MODE. Disparity state never crosses lanes.

## Timing
- Latency: exactly 2 PIXCLK cycles, input to TMDSencDATA. Throughput is one symbol per lane per cycle, with no stalls.
- **Reset (RST high at an edge):**
  - All pipeline registers clear, and every cnt becomes 0.
  - TMDSencDATA = control code 00 (1101010100) on every lane.
  - VALID = 0.
- **After reset:** VALID rises 2 cycles after the first edge with RST low.
- **Reset mid-frame:** reset overrides everything on that edge. Data in flight is discarded, not emitted.
- **Mode change:** takes effect per cycle with the 2-cycle latency.
  - The first video symbol after any non-video symbol is encoded with cnt=0.
  - A single-cycle non-video symbol between video symbols still clears cnt.

## Test plan
- **Reset:** RST held 3 cycles with MODE=01, DATA=0xFF → TMDSencDATA=1101010100 on all lanes and VALID=0. Release → VALID=1 two cycles later.
- **Disparity sequence:** MODE=01, lane 0 DATA=0x00 for 3 cycles from cnt=0 → lane 0 outputs 0100000000, 1111111111, 0100000000 with cnt -8, 2, -6. Lane 1 DATA=0xFF from cnt=0 → first output 1000000000, cnt -8.
- **Clearing:** video run leaving cnt≠0, then one MODE=00 cycle (CTRL=01 → 0010101011), then DATA=0x00 → output 0100000000, proving cnt was cleared.
- **TERC4 and guard band:**
  - MODE=10, AUX sweeps 0..F on all lanes → the 16 table codes in order, 2 cycles later.
  - MODE=11 with NUM_CH=3 → lanes 1011001100, 0100110011, 1011001100.
- **Reset mid-frame and lane independence:**
  - RST pulsed during a random video stream → next outputs are 1101010100, and cnt=0 on resume.
  - NUM_CH=4 random DATA on all lanes → each lane matches an independent reference model for 10^5 cycles, and every 10-symbol window keeps |cnt|≤10.
